// File: rtl/mult_share_sched_if.sv
// Bundles the L+R / L-R request and result channels plus the shared multiplier handshake.
// Latency: none, wiring only.
// Backpressure: none; requests are fire-and-forget strobes, the scheduler absorbs them in pending registers.
//
// Signals
//   lpr_in/lpr_req/ks, lmr_in/lmr_req/kd : sample, strobe and 4-bit gain per channel
//   mult_start/mult_a/mult_b             : start pulse and registered operands to the multiplier
//   mult_ready/mult_r                    : multiplier done level and signed 23-bit product
//   lpr_out/lpr_valid, lmr_out/lmr_valid : scaled, saturated results with 1-cycle strobes
//   overrun, timeout_err                 : sticky overwrite flags {lmr, lpr} and WAIT-abort strobe
interface mult_share_sched_if;
    logic [17:0] lpr_in;
    logic        lpr_req;
    logic [3:0]  ks;
    logic [17:0] lmr_in;
    logic        lmr_req;
    logic [3:0]  kd;
    logic        mult_start;
    logic [17:0] mult_a;
    logic [4:0]  mult_b;
    logic        mult_ready;
    logic [22:0] mult_r;
    logic [17:0] lpr_out;
    logic        lpr_valid;
    logic [17:0] lmr_out;
    logic        lmr_valid;
    logic [1:0]  overrun;
    logic        timeout_err;

    // Scheduler side
    modport slave (
        input  lpr_in, lpr_req, ks, lmr_in, lmr_req, kd, mult_ready, mult_r,
        output mult_start, mult_a, mult_b, lpr_out, lpr_valid, lmr_out, lmr_valid,
               overrun, timeout_err
    );

    // Requester / multiplier side
    modport master (
        output lpr_in, lpr_req, ks, lmr_in, lmr_req, kd, mult_ready, mult_r,
        input  mult_start, mult_a, mult_b, lpr_out, lpr_valid, lmr_out, lmr_valid,
               overrun, timeout_err
    );
endinterface

// File: rtl/mult_share_sched.sv
// Shares one 18x5 sequential multiplier between the L+R (Ks) and L-R (Kd) gain paths, round-robin.
// Latency: request to valid is 3 cycles plus the multiplier run time when idle.
// Backpressure: none; a new request overwrites an unserved pending sample and sets the sticky overrun bit.
//
// Ports
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-low
//   bus (slave) : request/result channels and multiplier handshake, see mult_share_sched_if
module mult_share_sched #(
    parameter int SHIFT   = 3,   // arithmetic right shift applied to the product
    parameter int TIMEOUT = 63   // WAIT counter value at which the run is abandoned
) (
    input  logic              clock,
    input  logic              reset,
    mult_share_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, STORE} state_t;

    localparam logic CH_LPR = 1'b0;
    localparam logic CH_LMR = 1'b1;
    localparam logic [5:0]         TIMEOUT_CNT = 6'(TIMEOUT);
    localparam logic signed [22:0] SAT_MAX     = 23'sd131071;
    localparam logic signed [22:0] SAT_MIN     = -23'sd131072;

    state_t      state_q, state_d;

    // Per-channel pending sample registers
    logic [17:0] lpr_smp_q, lmr_smp_q;
    logic [3:0]  lpr_k_q, lmr_k_q;
    logic        lpr_pend_q, lmr_pend_q;
    logic [1:0]  overrun_q;

    logic        last_grant_q;   // channel served most recently
    logic        grant_q;        // channel currently owning the multiplier
    logic [17:0] mult_a_q;
    logic [4:0]  mult_b_q;
    logic [5:0]  cnt_q;
    logic        ready_prev_q;
    logic [22:0] prod_q;

    logic [17:0] lpr_out_q, lmr_out_q;
    logic        lpr_valid_q, lmr_valid_q, timeout_q;

    logic        grant_en, grant_ch, grant_lpr, grant_lmr;
    logic        ready_rise, abort;
    logic signed [22:0] shifted;
    logic [17:0] sat;

    // Only a fresh rising edge completes a run, so a ready level left over
    // from an earlier (or reset-interrupted) run cannot be taken as a result.
    assign ready_rise = bus.mult_ready & ~ready_prev_q;

    // Next state and grant decision
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        grant_ch = ~last_grant_q;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (lpr_pend_q && lmr_pend_q) begin
                    grant_en = 1'b1;
                    grant_ch = ~last_grant_q;
                end else if (lpr_pend_q) begin
                    grant_en = 1'b1;
                    grant_ch = CH_LPR;
                end else if (lmr_pend_q) begin
                    grant_en = 1'b1;
                    grant_ch = CH_LMR;
                end
                if (grant_en) begin
                    state_d = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (ready_rise) begin
                    state_d = STORE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            STORE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant_lpr = grant_en && (grant_ch == CH_LPR);
    assign grant_lmr = grant_en && (grant_ch == CH_LMR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture. A request arriving in the grant cycle re-arms pend
    // (the granted copy is already on its way to the multiplier), so it is
    // not an overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lpr_smp_q  <= '0;
            lpr_k_q    <= '0;
            lpr_pend_q <= 1'b0;
            lmr_smp_q  <= '0;
            lmr_k_q    <= '0;
            lmr_pend_q <= 1'b0;
            overrun_q  <= '0;
        end else begin
            if (bus.lpr_req) begin
                lpr_smp_q  <= bus.lpr_in;
                lpr_k_q    <= bus.ks;
                lpr_pend_q <= 1'b1;
                if (lpr_pend_q && !grant_lpr) begin
                    overrun_q[0] <= 1'b1;
                end
            end else if (grant_lpr) begin
                lpr_pend_q <= 1'b0;
            end

            if (bus.lmr_req) begin
                lmr_smp_q  <= bus.lmr_in;
                lmr_k_q    <= bus.kd;
                lmr_pend_q <= 1'b1;
                if (lmr_pend_q && !grant_lmr) begin
                    overrun_q[1] <= 1'b1;
                end
            end else if (grant_lmr) begin
                lmr_pend_q <= 1'b0;
            end
        end
    end

    // Scale and saturate the registered product to 18-bit signed
    assign shifted = $signed(prod_q) >>> SHIFT;

    always_comb begin
        sat = shifted[17:0];
        if (shifted > SAT_MAX) begin
            sat = 18'h1FFFF;
        end else if (shifted < SAT_MIN) begin
            sat = 18'h20000;
        end
    end

    // Operand load, run supervision and result write-back
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= CH_LMR;   // LpR wins the first tie
            grant_q      <= CH_LPR;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            cnt_q        <= '0;
            ready_prev_q <= 1'b0;
            prod_q       <= '0;
            lpr_out_q    <= '0;
            lmr_out_q    <= '0;
            lpr_valid_q  <= 1'b0;
            lmr_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            ready_prev_q <= bus.mult_ready;
            lpr_valid_q  <= 1'b0;
            lmr_valid_q  <= 1'b0;
            timeout_q    <= abort;

            // Operands only change here, so they stay put through START and WAIT
            if (grant_en) begin
                grant_q      <= grant_ch;
                last_grant_q <= grant_ch;
                mult_a_q     <= grant_lpr ? lpr_smp_q : lmr_smp_q;
                mult_b_q     <= {1'b0, (grant_lpr ? lpr_k_q : lmr_k_q)};
            end

            if (state_q == START) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 6'd1;
            end

            if (state_q == WAIT && ready_rise) begin
                prod_q <= bus.mult_r;
            end

            if (state_q == STORE) begin
                if (grant_q == CH_LPR) begin
                    lpr_out_q   <= sat;
                    lpr_valid_q <= 1'b1;
                end else begin
                    lmr_out_q   <= sat;
                    lmr_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.mult_start  = (state_q == START);
    assign bus.mult_a      = mult_a_q;
    assign bus.mult_b      = mult_b_q;
    assign bus.lpr_out     = lpr_out_q;
    assign bus.lpr_valid   = lpr_valid_q;
    assign bus.lmr_out     = lmr_out_q;
    assign bus.lmr_valid   = lmr_valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a behavioural sequential multiplier.
// Latency: multiplier model answers a configurable number of cycles after start.
// Backpressure: none; the bench can suppress the multiplier response to force timeouts.
module tb_mult_share_sched;
    logic clock;
    logic reset;

    mult_share_sched_if bus();

    mult_share_sched dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Multiplier model
    logic              m_ready;
    logic [22:0]       m_r;
    logic              stale_ready;
    logic              mult_en;
    int                mult_lat;
    int                m_cnt;
    int                m_hold;
    logic signed [22:0] ea, eb, m_prod;

    assign bus.mult_ready = m_ready | stale_ready;
    assign bus.mult_r     = m_r;

    initial begin
        m_ready = 1'b0;
        m_r     = '0;
        m_cnt   = 0;
        m_hold  = 0;
    end

    always @(negedge clock) begin
        if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_ready = 1'b0;
        end
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_r     = m_prod;
                m_ready = 1'b1;
                m_hold  = 2;
            end
        end
        if (bus.mult_start && mult_en) begin
            ea     = {{5{bus.mult_a[17]}}, bus.mult_a};
            eb     = {18'b0, bus.mult_b};
            m_prod = ea * eb;
            m_cnt  = mult_lat;
        end
    end

    // Output monitor
    int   cyc = 0;
    int   start_cnt = 0;
    int   start_cyc = 0;
    int   to_cnt = 0;
    int   to_cyc = 0;
    int   both_hi = 0;
    logic [17:0] cap_a;
    logic [4:0]  cap_b;
    int   svc_ch[$];
    logic [17:0] svc_val[$];

    always @(negedge clock) begin
        cyc++;
        if (bus.mult_start) begin
            start_cnt++;
            start_cyc = cyc;
            cap_a     = bus.mult_a;
            cap_b     = bus.mult_b;
        end
        if (bus.lpr_valid) begin
            svc_ch.push_back(0);
            svc_val.push_back(bus.lpr_out);
        end
        if (bus.lmr_valid) begin
            svc_ch.push_back(1);
            svc_val.push_back(bus.lmr_out);
        end
        if (bus.lpr_valid && bus.lmr_valid) both_hi++;
        if (bus.timeout_err) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req_lpr(input logic [17:0] v, input logic [3:0] k);
        bus.lpr_in = v; bus.ks = k; bus.lpr_req = 1'b1;
        tick();
        bus.lpr_req = 1'b0;
    endtask

    task automatic req_lmr(input logic [17:0] v, input logic [3:0] k);
        bus.lmr_in = v; bus.kd = k; bus.lmr_req = 1'b1;
        tick();
        bus.lmr_req = 1'b0;
    endtask

    task automatic req_both(input logic [17:0] va, input logic [3:0] ka,
                            input logic [17:0] vb, input logic [3:0] kb);
        bus.lpr_in = va; bus.ks = ka; bus.lpr_req = 1'b1;
        bus.lmr_in = vb; bus.kd = kb; bus.lmr_req = 1'b1;
        tick();
        bus.lpr_req = 1'b0;
        bus.lmr_req = 1'b0;
    endtask

    // Bounded wait until n results have been seen in total
    task automatic wait_svc(input int n, input string tag);
        for (int i = 0; i < 300 && svc_ch.size() < n; i++) tick();
        chk(tag, svc_ch.size(), n);
    endtask

    task automatic wait_start(input int n, input string tag);
        for (int i = 0; i < 100 && start_cnt < n; i++) tick();
        chk(tag, start_cnt, n);
    endtask

    task automatic expect_svc(input int idx, input int ch, input logic [17:0] val, input string tag);
        int          oc;
        logic [17:0] ov;
        oc = (idx < svc_ch.size()) ? svc_ch[idx] : -1;
        ov = (idx < svc_val.size()) ? svc_val[idx] : 18'h0;
        chk({tag, "_ch"}, oc, ch);
        chk({tag, "_val"}, {14'b0, ov}, {14'b0, val});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ticks(2);
        reset = 1'b1;
        tick();
    endtask

    int n0, s0, t0, dt;

    initial begin
        reset       = 1'b0;
        bus.lpr_in  = '0; bus.lpr_req = 1'b0; bus.ks = '0;
        bus.lmr_in  = '0; bus.lmr_req = 1'b0; bus.kd = '0;
        stale_ready = 1'b0;
        mult_en     = 1'b1;
        mult_lat    = 4;
        ticks(3);

        // Reset state
        chk("rst_lpr_out", {14'b0, bus.lpr_out}, 32'h0);
        chk("rst_lmr_out", {14'b0, bus.lmr_out}, 32'h0);
        chk("rst_valids", {30'b0, bus.lpr_valid, bus.lmr_valid}, 32'h0);
        chk("rst_overrun", {30'b0, bus.overrun}, 32'h0);
        chk("rst_timeout", {31'b0, bus.timeout_err}, 32'h0);
        chk("rst_start", {31'b0, bus.mult_start}, 32'h0);
        chk("rst_ops", {9'b0, bus.mult_a, bus.mult_b}, 32'h0);
        reset = 1'b1;
        tick();

        // 1: 1000 * 8 = 8000, >>>3 = 1000
        n0 = svc_ch.size(); s0 = start_cnt;
        req_lpr(18'd1000, 4'd8);
        wait_svc(n0 + 1, "t1_wait");
        chk("t1_starts", start_cnt - s0, 1);
        chk("t1_a", {14'b0, cap_a}, 32'd1000);
        chk("t1_b", {27'b0, cap_b}, 32'd8);
        expect_svc(n0, 0, 18'd1000, "t1");
        ticks(6);
        chk("t1_single", svc_ch.size(), n0 + 1);

        // 2: 131071*15 = 1966065 -> 245758 saturates high; -131072*15 -> -245760 saturates low
        n0 = svc_ch.size();
        req_lpr(18'h1FFFF, 4'd15);
        wait_svc(n0 + 1, "t2p_wait");
        expect_svc(n0, 0, 18'h1FFFF, "t2p");
        req_lmr(18'h20000, 4'd15);
        wait_svc(n0 + 2, "t2n_wait");
        expect_svc(n0 + 1, 1, 18'h20000, "t2n");
        // -9*1 = -9, arithmetic >>>3 floors to -2
        req_lmr(18'h3FFF7, 4'd1);
        wait_svc(n0 + 3, "t2f_wait");
        expect_svc(n0 + 2, 1, 18'h3FFFE, "t2f");

        // 3: simultaneous requests after reset -> LpR first (100*4>>>3=50), then LmR (-80*2>>>3=-20)
        do_reset();
        n0 = svc_ch.size();
        req_both(18'd100, 4'd4, 18'h3FFB0, 4'd2);
        wait_svc(n0 + 2, "t3a_wait");
        expect_svc(n0, 0, 18'd50, "t3a0");
        expect_svc(n0 + 1, 1, 18'h3FFEC, "t3a1");
        // With LpR served last (16*1>>>3=2), the next tie goes to LmR
        req_lpr(18'd16, 4'd1);
        wait_svc(n0 + 3, "t3b_wait");
        expect_svc(n0 + 2, 0, 18'd2, "t3b");
        req_both(18'd24, 4'd3, 18'h3FFF8, 4'd1);
        wait_svc(n0 + 5, "t3c_wait");
        expect_svc(n0 + 3, 1, 18'h3FFFF, "t3c0");
        expect_svc(n0 + 4, 0, 18'd9, "t3c1");
        chk("t3_overrun", {30'b0, bus.overrun}, 32'h0);

        // 4: two requests during one WAIT; only the later (7*8>>>3=7) is served
        mult_lat = 12;
        n0 = svc_ch.size(); s0 = start_cnt;
        req_lpr(18'd40, 4'd8);
        wait_start(s0 + 1, "t4_start");
        tick();
        req_lpr(18'd5, 4'd8);
        req_lpr(18'd7, 4'd8);
        chk("t4_overrun_set", {30'b0, bus.overrun}, 32'h1);
        wait_svc(n0 + 2, "t4_wait");
        expect_svc(n0, 0, 18'd40, "t4a");
        expect_svc(n0 + 1, 0, 18'd7, "t4b");
        ticks(25);
        chk("t4_no_extra", svc_ch.size(), n0 + 2);
        mult_lat = 4;
        req_lmr(18'd8, 4'd8);
        wait_svc(n0 + 3, "t4c_wait");
        chk("t4_overrun_sticky", {30'b0, bus.overrun}, 32'h1);

        // 5: multiplier never answers -> abort about TIMEOUT cycles after start
        mult_en = 1'b0;
        n0 = svc_ch.size(); s0 = start_cnt; t0 = to_cnt;
        req_lmr(18'd50, 4'd4);
        wait_start(s0 + 1, "t5_start");
        for (int i = 0; i < 100 && to_cnt == t0; i++) tick();
        chk("t5_timeout_cnt", to_cnt - t0, 1);
        dt = to_cyc - start_cyc;
        chk("t5_timeout_window", {31'b0, (dt >= 63 && dt <= 65)}, 32'h1);
        ticks(4);
        chk("t5_pulse_once", to_cnt - t0, 1);
        chk("t5_no_valid", svc_ch.size(), n0);
        mult_en = 1'b1;
        req_lmr(18'd16, 4'd8);
        wait_svc(n0 + 1, "t5_recover_wait");
        expect_svc(n0, 1, 18'd16, "t5_recover");

        // 6: reset in the middle of WAIT with another request pending
        mult_en = 1'b0;
        n0 = svc_ch.size(); s0 = start_cnt;
        req_lpr(18'd100, 4'd8);
        wait_start(s0 + 1, "t6_start");
        ticks(3);
        req_lmr(18'd9, 4'd1);
        reset = 1'b0;
        #1;
        chk("t6_lpr_out", {14'b0, bus.lpr_out}, 32'h0);
        chk("t6_lmr_out", {14'b0, bus.lmr_out}, 32'h0);
        chk("t6_overrun", {30'b0, bus.overrun}, 32'h0);
        chk("t6_ops", {9'b0, bus.mult_a, bus.mult_b}, 32'h0);
        chk("t6_start", {31'b0, bus.mult_start}, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        stale_ready = 1'b1;
        ticks(12);
        stale_ready = 1'b0;
        chk("t6_no_restart", start_cnt - s0, 1);
        chk("t6_no_valid", svc_ch.size(), n0);
        mult_en = 1'b1;
        req_lpr(18'd8, 4'd8);
        wait_svc(n0 + 1, "t6_after_wait");
        expect_svc(n0, 0, 18'd8, "t6_after");

        ticks(3);
        chk("never_both_valid", both_hi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
